mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: fetch (if_*) and data (dm_*) clients share one
// memory-controller port, with a single transaction outstanding at a time.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [1:0]              if_rw_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic [DATA_WIDTH-1:0]   if_data_i,
    input  logic [DATA_WIDTH/8-1:0] if_mask_i,
    output logic [DATA_WIDTH-1:0]   if_data_o,
    output logic                    if_busy_o,
    output logic                    if_done_o,

    input  logic [1:0]              dm_rw_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_data_i,
    input  logic [DATA_WIDTH/8-1:0] dm_mask_i,
    output logic [DATA_WIDTH-1:0]   dm_data_o,
    output logic                    dm_busy_o,
    output logic                    dm_done_o,

    output logic [1:0]              mem_rw_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    output logic [DATA_WIDTH/8-1:0] mem_mask_o,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic                    mem_busy_i,
    input  logic                    mem_done_i
);

    // state | meaning
    // IDLE  | nothing outstanding; arbitrate between eligible clients
    // WAIT  | request issued; first cycle drives mem_rw_o, then await mem_done_i

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic                    issue, issue_nxt;
    // Owner of the outstanding transaction; also remembers the last winner for tie-breaks.
    logic                    grant_dm, grant_dm_nxt;

    logic [1:0]              mem_rw_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   mem_data_nxt;
    logic [MASK_WIDTH-1:0]   mem_mask_nxt;
    logic [DATA_WIDTH-1:0]   if_data_nxt, dm_data_nxt;
    logic                    if_busy_nxt, dm_busy_nxt;
    logic                    if_done_nxt, dm_done_nxt;

    logic                    if_req, dm_req;
    logic                    if_elig, dm_elig;
    logic                    pick_dm;

    assign if_req  = (if_rw_i == 2'b01) || (if_rw_i == 2'b10);
    assign dm_req  = (dm_rw_i == 2'b01) || (dm_rw_i == 2'b10);
    // A client completing this cycle is not re-granted in the same cycle.
    assign if_elig = if_req && !if_done_o;
    assign dm_elig = dm_req && !dm_done_o;
    assign pick_dm = dm_elig && (!if_elig || !grant_dm);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            issue      <= 1'b0;
            grant_dm   <= 1'b0;
            mem_rw_o   <= 2'b00;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_mask_o <= '0;
            if_data_o  <= '0;
            dm_data_o  <= '0;
            if_busy_o  <= 1'b0;
            dm_busy_o  <= 1'b0;
            if_done_o  <= 1'b0;
            dm_done_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            issue      <= issue_nxt;
            grant_dm   <= grant_dm_nxt;
            mem_rw_o   <= mem_rw_nxt;
            mem_addr_o <= mem_addr_nxt;
            mem_data_o <= mem_data_nxt;
            mem_mask_o <= mem_mask_nxt;
            if_data_o  <= if_data_nxt;
            dm_data_o  <= dm_data_nxt;
            if_busy_o  <= if_busy_nxt;
            dm_busy_o  <= dm_busy_nxt;
            if_done_o  <= if_done_nxt;
            dm_done_o  <= dm_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issue_nxt    = 1'b0;
        grant_dm_nxt = grant_dm;
        mem_rw_nxt   = 2'b00;
        mem_addr_nxt = mem_addr_o;
        mem_data_nxt = mem_data_o;
        mem_mask_nxt = mem_mask_o;
        if_data_nxt  = if_data_o;
        dm_data_nxt  = dm_data_o;
        if_busy_nxt  = if_busy_o;
        dm_busy_nxt  = dm_busy_o;
        if_done_nxt  = 1'b0;
        dm_done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!mem_busy_i && (if_elig || dm_elig)) begin
                    state_nxt    = ST_WAIT;
                    issue_nxt    = 1'b1;
                    grant_dm_nxt = pick_dm;
                    if (pick_dm) begin
                        mem_rw_nxt   = dm_rw_i;
                        mem_addr_nxt = dm_addr_i;
                        mem_data_nxt = dm_data_i;
                        mem_mask_nxt = dm_mask_i;
                        dm_busy_nxt  = 1'b1;
                        if_busy_nxt  = 1'b0;
                    end else begin
                        mem_rw_nxt   = if_rw_i;
                        mem_addr_nxt = if_addr_i;
                        mem_data_nxt = if_data_i;
                        mem_mask_nxt = if_mask_i;
                        if_busy_nxt  = 1'b1;
                        dm_busy_nxt  = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                // Completion during the issue cycle belongs to no transaction.
                if (!issue && mem_done_i) begin
                    state_nxt = ST_IDLE;
                    if (grant_dm) begin
                        dm_done_nxt = 1'b1;
                        dm_busy_nxt = 1'b0;
                        dm_data_nxt = mem_data_i;
                    end else begin
                        if_done_nxt = 1'b1;
                        if_busy_nxt = 1'b0;
                        if_data_nxt = mem_data_i;
                    end
                end
            end
        endcase
    end

endmodule
